sram_fifo_ctrl: RTL

Parametrised FIFO controller that keeps its storage in an external single-port asynchronous SRAM with active-low strobes. It replaces the fixed 16-bit/8-entry controller. New capabilities:
- valid/ready handshakes on both sides
- round-robin arbitration when a write and a read are pending together
- an exact occupancy count with almost-full/almost-empty thresholds
- sticky overflow/underflow flags
- a configurable strobe width

It sits between a producer/consumer pair and the board SRAM pins. Any tristate merging of the SRAM data bus is done at top level.

---
 rtl/sram_fifo_pkg.sv | 22 ++
 rtl/sram_fifo_ctrl_if.sv | 40 ++++
 rtl/sram_access_seq.sv | 107 ++++++++++
 rtl/sram_fifo_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared types and constants for the SRAM-backed FIFO controller.
//   ST_*      : access sequencer state encoding (IDLE/SETUP/STROBE/DONE)
//   op_e      : access operation chosen at grant (write / read)
//   STB_OFF   : inactive level of the active-low SRAM strobes
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

    localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl_if
// Producer/consumer side of the SRAM FIFO controller.
//   wr_en/wr_data/wr_ready : write handshake (data held until wr_ready)
//   rd_en/rd_ready         : read handshake
//   rd_data/rd_valid       : last word read and its one-cycle update pulse
//   count + status flags   : occupancy, full/empty/almost, sticky errors
// master = producer/consumer, slave = controller.
// -----------------------------------------------------------------------------
interface sram_fifo_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_ready, rd_ready, rd_data, rd_valid, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_ready, rd_ready, rd_data, rd_valid, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sram_access_seq.sv
// -----------------------------------------------------------------------------
// sram_access_seq
// Timing sequencer for one asynchronous SRAM access: SETUP (1 cycle),
// STROBE (WAIT_CYC cycles), DONE (1 cycle). A new access may start from IDLE
// or straight out of DONE, so back-to-back accesses have no idle gap.
//   clk, rst   : clock, synchronous active-low reset
//   i_start    : begin an access with operation i_op (sampled in IDLE/DONE)
//   o_op       : operation of the access in flight
//   o_idle     : sequencer is in IDLE
//   o_done     : sequencer is in DONE (one cycle per access)
//   o_capture  : last STROBE cycle of a read; read data is valid this cycle
//   o_ce_n/o_oe_n/o_we_n : registered active-low SRAM strobes
// -----------------------------------------------------------------------------
module sram_access_seq
    import sram_fifo_pkg::*;
#(
    parameter int WAIT_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  op_e  i_op,
    output op_e  o_op,
    output logic o_idle,
    output logic o_done,
    output logic o_capture,
    output logic o_ce_n,
    output logic o_oe_n,
    output logic o_we_n
);
    localparam int            CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYC - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_wcnt;
    op_e           r_op;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_we_n;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_wcnt_nxt;
    op_e           w_op_nxt;
    logic          w_last_stb;

    assign w_last_stb = (r_state == ST_STROBE) && (r_wcnt == LAST_CNT);
    assign o_op       = r_op;
    assign o_idle     = (r_state == ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_capture  = w_last_stb && (r_op == OP_RD);
    assign o_ce_n     = r_ce_n;
    assign o_oe_n     = r_oe_n;
    assign o_we_n     = r_we_n;

    // Next state, strobe-cycle counter and op selection
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_wcnt_nxt = '0;
                if (i_start) begin
                    w_state_nxt = ST_SETUP;
                    w_op_nxt    = i_op;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
                w_wcnt_nxt  = '0;
            end
            ST_STROBE: begin
                if (w_last_stb) begin
                    w_state_nxt = ST_DONE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    // State register; strobes are decoded from the next state so they are glitch-free flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_op    <= OP_RD;
            r_ce_n  <= STB_OFF;
            r_oe_n  <= STB_OFF;
            r_we_n  <= STB_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_op    <= w_op_nxt;
            r_ce_n  <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE));
            r_we_n  <= !((w_state_nxt == ST_STROBE) && (w_op_nxt == OP_WR));
            r_oe_n  <= !((w_state_nxt == ST_STROBE) && (w_op_nxt == OP_RD));
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// FIFO controller whose storage is an external single-port asynchronous SRAM.
// One write and one read request can be pending; when both are, the op not
// served last is granted. Occupancy changes only when an access completes.
//   clk, rst        : clock, synchronous active-low reset
//   fifo (slave)    : producer/consumer handshakes, read data, count, flags
//   o_sram_addr     : SRAM address
//   o_sram_wdata    : SRAM write data (tristate merge done above this block)
//   i_sram_rdata    : SRAM read data
//   o_sram_ce_n/oe_n/we_n : active-low SRAM strobes
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 2048,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_fifo_ctrl_if.slave   fifo,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);
    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_pend;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_hold;
    op_e               r_last;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;

    logic w_full, w_empty, w_wr_ready, w_rd_ready, w_wr_acc, w_rd_acc;
    logic w_seq_idle, w_seq_done, w_capture, w_fin_wr, w_fin_rd;
    logic w_pw, w_pr, w_start;
    op_e  w_cur_op, w_last_eff, w_grant_op;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] v;
        if (p == ADDR_W'(DEPTH - 1)) begin
            v = '0;
        end else begin
            v = p + ADDR_W'(1);
        end
        return v;
    endfunction

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_wr_ready   = !r_wr_pend && !w_full;
    assign w_rd_ready   = !r_rd_pend && !w_empty;
    assign w_wr_acc     = fifo.wr_en && w_wr_ready;
    assign w_rd_acc     = fifo.rd_en && w_rd_ready;

    // An access in DONE is completing: its own pend flag no longer competes,
    // and it already counts as the last-served op for arbitration.
    assign w_fin_wr     = w_seq_done && (w_cur_op == OP_WR);
    assign w_fin_rd     = w_seq_done && (w_cur_op == OP_RD);
    assign w_pw         = r_wr_pend && !w_fin_wr;
    assign w_pr         = r_rd_pend && !w_fin_rd;
    assign w_last_eff   = w_seq_done ? w_cur_op : r_last;

    assign fifo.wr_ready     = w_wr_ready;
    assign fifo.rd_ready     = w_rd_ready;
    assign fifo.rd_data      = r_rd_data;
    assign fifo.rd_valid     = r_rd_valid;
    assign fifo.count        = r_count;
    assign fifo.full         = w_full;
    assign fifo.empty        = w_empty;
    assign fifo.almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign fifo.almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign fifo.overflow     = r_ovf;
    assign fifo.underflow    = r_udf;
    assign o_sram_addr       = r_sram_addr;
    assign o_sram_wdata      = r_sram_wdata;

    // Round-robin grant, evaluated while the sequencer is in IDLE or DONE
    always_comb begin
        w_start    = 1'b0;
        w_grant_op = OP_WR;
        if ((w_seq_idle || w_seq_done) && (w_pw || w_pr)) begin
            w_start = 1'b1;
            if (w_pw && w_pr) begin
                w_grant_op = (w_last_eff == OP_RD) ? OP_WR : OP_RD;
            end else if (w_pw) begin
                w_grant_op = OP_WR;
            end else begin
                w_grant_op = OP_RD;
            end
        end else begin
            w_start = 1'b0;
        end
    end

    sram_access_seq #(
        .WAIT_CYC (WAIT_CYC)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_op      (w_grant_op),
        .o_op      (w_cur_op),
        .o_idle    (w_seq_idle),
        .o_done    (w_seq_done),
        .o_capture (w_capture),
        .o_ce_n    (o_sram_ce_n),
        .o_oe_n    (o_sram_oe_n),
        .o_we_n    (o_sram_we_n)
    );

    // Handshake acceptance, pointers, occupancy and arbitration history
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_hold    <= '0;
            r_last    <= OP_RD;
        end else begin
            if (w_wr_acc) begin
                r_wr_pend <= 1'b1;
                r_hold    <= fifo.wr_data;
            end else if (w_fin_wr) begin
                r_wr_pend <= 1'b0;
            end
            if (w_rd_acc) begin
                r_rd_pend <= 1'b1;
            end else if (w_fin_rd) begin
                r_rd_pend <= 1'b0;
            end
            if (w_fin_wr) begin
                r_wp    <= ptr_inc(r_wp);
                r_count <= r_count + CNT_W'(1);
                r_last  <= OP_WR;
            end else if (w_fin_rd) begin
                r_rp    <= ptr_inc(r_rp);
                r_count <= r_count - CNT_W'(1);
                r_last  <= OP_RD;
            end
        end
    end

    // SRAM address/data launched at grant and held through DONE; read capture; sticky errors
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            if (w_start) begin
                if (w_grant_op == OP_WR) begin
                    r_sram_addr  <= r_wp;
                    r_sram_wdata <= r_hold;
                end else begin
                    r_sram_addr  <= r_rp;
                end
            end
            if (w_capture) begin
                r_rd_data <= i_sram_rdata;
            end
            r_rd_valid <= w_capture;
            if (fifo.wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
            if (fifo.rd_en && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

endmodule
